rr_priority_encoder: RTL and testbench

Parametrised N-to-log2(N) encoder for arbitrary multi-hot request vectors. Invalid inputs no longer produce an undefined output.
- Selectable fixed-priority or round-robin selection.
- Status flags for zero-hot and multi-hot inputs, plus a population count.
- One-deep registered output stage with valid/ready handshake on both sides.
- Sits between request sources (interrupt lines, channel requests) and downstream consumers that need a binary index.

---
 rtl/rr_priority_encoder.sv | 98 +++++++++
 tb/tb_rr_priority_encoder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rr_priority_encoder.sv
// Multi-hot request encoder with fixed or round-robin selection,
// zero/multi flags, population count and a one-deep output register.
module rr_priority_encoder #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] idx,
  output logic         zero,
  output logic         multi,
  output logic [W:0]   cnt
);

  logic [W-1:0]   ptr;
  logic [W-1:0]   fix_idx;
  logic [W-1:0]   rr_idx;
  logic [W-1:0]   sel_idx;
  logic [W-1:0]   rot_k;
  logic [W:0]     rr_sum;
  logic [W:0]     pop;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic           any;
  logic           accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign any      = |req;

  // Fixed priority: lowest set bit wins.
  always_comb begin
    fix_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) fix_idx = W'(i);
    end
  end

  // Round-robin: rotate req so ptr lands at bit 0, find the
  // lowest set bit, then map the offset back modulo N.
  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[N-1:0];
    rot_k = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) rot_k = W'(i);
    end
    rr_sum = {1'b0, ptr} + {1'b0, rot_k};
    if (rr_sum >= (W+1)'(N)) rr_sum = rr_sum - (W+1)'(N);
    rr_idx = rr_sum[W-1:0];
  end

  // Population count over all N request bits.
  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + (W+1)'(req[i]);
    end
  end

  assign sel_idx = mode ? rr_idx : fix_idx;

  // Round-robin pointer: advances past the winner on a nonzero RR accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept && mode && any) begin
      if (sel_idx == W'(N - 1)) ptr <= '0;
      else                      ptr <= sel_idx + W'(1);
    end
  end

  // Output stage: load on accept, drop valid on a lone consume.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      idx       <= '0;
      zero      <= 1'b0;
      multi     <= 1'b0;
      cnt       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      idx       <= any ? sel_idx : '0;
      zero      <= !any;
      multi     <= pop >= (W+1)'(2);
      cnt       <= pop;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Directed-vector bench for rr_priority_encoder (N = 16).
// Table of back-to-back accepts plus hand sequences for stalls/reset.
module tb_rr_priority_encoder;

  localparam int N = 16;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mode;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] req;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] idx;
  logic         zero;
  logic         multi;
  logic [W:0]   cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         mode;
    logic [N-1:0] req;
    logic [W-1:0] idx;
    logic         zero;
    logic         multi;
    logic [W:0]   cnt;
  } vec_t;

  vec_t vecs [64];
  int   nv;

  rr_priority_encoder #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .req       (req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .idx       (idx),
    .zero      (zero),
    .multi     (multi),
    .cnt       (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic m, input logic [N-1:0] r,
                     input int i, input logic z, input logic mu,
                     input int c);
    vecs[nv].mode  = m;
    vecs[nv].req   = r;
    vecs[nv].idx   = W'(i);
    vecs[nv].zero  = z;
    vecs[nv].multi = mu;
    vecs[nv].cnt   = (W+1)'(c);
    nv++;
  endtask

  task automatic chk_out(input string tag, input int i, input int z,
                         input int mu, input int c);
    chk({tag, ".valid"}, int'(out_valid), 1);
    chk({tag, ".idx"},   int'(idx),       i);
    chk({tag, ".zero"},  int'(zero),      z);
    chk({tag, ".multi"}, int'(multi),     mu);
    chk({tag, ".cnt"},   int'(cnt),       c);
  endtask

  initial begin
    nv = 0;
    for (int k = 0; k < N; k++) add(1'b0, 16'(1) << k, k, 1'b0, 1'b0, 1);
    add(1'b0, 16'h0000,  0, 1'b1, 1'b0,  0);
    add(1'b0, 16'hA0A0,  5, 1'b0, 1'b1,  4);
    add(1'b0, 16'hFFFF,  0, 1'b0, 1'b1, 16);
    // RR from ptr=0: 0 -> ptr1, 4 -> ptr5, 15 -> ptr0, 0 -> ptr1
    add(1'b1, 16'h8011,  0, 1'b0, 1'b1,  3);
    add(1'b1, 16'h8011,  4, 1'b0, 1'b1,  3);
    add(1'b1, 16'h8011, 15, 1'b0, 1'b1,  3);
    add(1'b1, 16'h8011,  0, 1'b0, 1'b1,  3);
    // zero input leaves ptr at 1
    add(1'b1, 16'h0000,  0, 1'b1, 1'b0,  0);
    // scan 1..15,0 finds bit 0; ptr stays 1
    add(1'b1, 16'h0001,  0, 1'b0, 1'b0,  1);
    // fixed mode freezes ptr
    add(1'b0, 16'h8000, 15, 1'b0, 1'b0,  1);
    // ptr=1 -> bit 1 wins, ptr becomes 2
    add(1'b1, 16'h0003,  1, 1'b0, 1'b1,  2);
    // ptr=2 -> bit 3 before bit 0
    add(1'b1, 16'h0009,  3, 1'b0, 1'b1,  2);

    // reset held with a live request: reset wins
    rst_n     = 1'b0;
    mode      = 1'b0;
    in_valid  = 1'b1;
    req       = 16'h0001;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst.valid", int'(out_valid), 0);
    chk("rst.idx",   int'(idx),       0);
    chk("rst.cnt",   int'(cnt),       0);
    chk("rst.ready", int'(in_ready),  1);

    // release and run the table back-to-back
    rst_n = 1'b1;
    for (int v = 0; v < nv; v++) begin
      mode = vecs[v].mode;
      req  = vecs[v].req;
      tick();
      chk_out($sformatf("vec%0d", v), int'(vecs[v].idx),
              int'(vecs[v].zero), int'(vecs[v].multi),
              int'(vecs[v].cnt));
    end

    // backpressure: accept, then stall three cycles
    mode = 1'b0;
    req  = 16'h0010;
    tick();
    chk_out("bp.load", 4, 0, 0, 1);
    out_ready = 1'b0;
    req       = 16'h0100;
    mode      = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk($sformatf("bp%0d.ready", s), int'(in_ready), 0);
      chk_out($sformatf("bp%0d", s), 4, 0, 0, 1);
    end
    // consume and load on the same edge
    mode      = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp.ready_comb", int'(in_ready), 1);
    tick();
    chk_out("bp.swap", 8, 0, 0, 1);
    in_valid = 1'b0;
    tick();
    chk("bp.drain", int'(out_valid), 0);

    // drive ptr to 5 (ptr is 4 now? no: fixed mode kept it at 4)
    in_valid = 1'b1;
    mode     = 1'b1;
    req      = 16'h0010;
    tick();
    chk_out("mr.pre", 4, 0, 0, 1);
    // mid-operation reset with a live request
    rst_n = 1'b0;
    req   = 16'h0021;
    tick();
    chk("mr.valid", int'(out_valid), 0);
    chk("mr.idx",   int'(idx),       0);
    rst_n = 1'b1;
    tick();
    chk_out("mr.post", 0, 0, 1, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
